// File: rtl/load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit : splits 1/2/4/8-byte little-endian requests into byte lanes
// Revision: 1.0
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_wdata,
  output logic                  resp_valid,
  output logic [63:0]           resp_rdata,
  output logic [ADDR_WIDTH-1:0] data_rd1,
  output logic [ADDR_WIDTH-1:0] data_rd2,
  output logic [ADDR_WIDTH-1:0] data_rd3,
  output logic [ADDR_WIDTH-1:0] data_rd4,
  input  logic [7:0]            data_rd1_out,
  input  logic [7:0]            data_rd2_out,
  input  logic [7:0]            data_rd3_out,
  input  logic [7:0]            data_rd4_out,
  output logic [ADDR_WIDTH-1:0] data_wr1,
  output logic [ADDR_WIDTH-1:0] data_wr2,
  output logic [ADDR_WIDTH-1:0] data_wr3,
  output logic [ADDR_WIDTH-1:0] data_wr4,
  output logic [7:0]            data_wr1_data,
  output logic [7:0]            data_wr2_data,
  output logic [7:0]            data_wr3_data,
  output logic [7:0]            data_wr4_data,
  output logic                  data_wr1_enable,
  output logic                  data_wr2_enable,
  output logic                  data_wr3_enable,
  output logic                  data_wr4_enable
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic                  signed_q, signed_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [31:0]           lo_q, lo_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [63:0]           resp_rdata_q, resp_rdata_d;

  logic [3:0]            w_lane_act;
  logic [ADDR_WIDTH-1:0] w_lane_addr [4];
  logic [ADDR_WIDTH-1:0] w_rd_addr   [4];
  logic [ADDR_WIDTH-1:0] w_wr_addr   [4];
  logic [7:0]            w_wr_data   [4];
  logic [3:0]            w_wr_en;
  logic [31:0]           w_rd_word;
  logic [63:0]           w_load_ext;
  logic                  w_fill;
  int                    w_off;

  assign req_ready = (state_q == IDLE) && reset;
  assign w_rd_word = {data_rd4_out, data_rd3_out, data_rd2_out, data_rd1_out};

  // Lane drive depends only on state and the latched request.
  always_comb begin
    w_off = (state_q == BEAT1) ? 4 : 0;
    unique case (size_q)
      2'b00:   w_lane_act = 4'b0001;
      2'b01:   w_lane_act = 4'b0011;
      default: w_lane_act = 4'b1111;
    endcase
    if (state_q == IDLE) w_lane_act = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_lane_addr[i] = addr_q + ADDR_WIDTH'(i + w_off);
      w_rd_addr[i]   = (w_lane_act[i] && !write_q) ? w_lane_addr[i] : '0;
      w_wr_addr[i]   = (w_lane_act[i] &&  write_q) ? w_lane_addr[i] : '0;
      w_wr_data[i]   = (w_lane_act[i] &&  write_q) ? wdata_q[8*(i + w_off) +: 8] : 8'h00;
      w_wr_en[i]     = w_lane_act[i] && write_q;
    end
  end

  always_comb begin
    w_fill     = 1'b0;
    w_load_ext = 64'h0;
    unique case (size_q)
      2'b00: begin
        w_fill     = signed_q & data_rd1_out[7];
        w_load_ext = {{56{w_fill}}, data_rd1_out};
      end
      2'b01: begin
        w_fill     = signed_q & data_rd2_out[7];
        w_load_ext = {{48{w_fill}}, data_rd2_out, data_rd1_out};
      end
      default: begin
        w_fill     = signed_q & data_rd4_out[7];
        w_load_ext = {{32{w_fill}}, w_rd_word};
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    write_d      = write_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d   = req_addr;
          size_d   = req_size;
          write_d  = req_write;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          state_d  = BEAT0;
        end
      end
      BEAT0: begin
        if (size_q == 2'b11) begin
          lo_d    = w_rd_word;
          state_d = BEAT1;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? 64'h0 : w_load_ext;
          state_d      = IDLE;
        end
      end
      BEAT1: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = write_q ? 64'h0 : {w_rd_word, lo_q};
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= 2'b00;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      wdata_q      <= 64'h0;
      lo_q         <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'h0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      write_q      <= write_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign data_rd1        = w_rd_addr[0];
  assign data_rd2        = w_rd_addr[1];
  assign data_rd3        = w_rd_addr[2];
  assign data_rd4        = w_rd_addr[3];
  assign data_wr1        = w_wr_addr[0];
  assign data_wr2        = w_wr_addr[1];
  assign data_wr3        = w_wr_addr[2];
  assign data_wr4        = w_wr_addr[3];
  assign data_wr1_data   = w_wr_data[0];
  assign data_wr2_data   = w_wr_data[1];
  assign data_wr3_data   = w_wr_data[2];
  assign data_wr4_data   = w_wr_data[3];
  assign data_wr1_enable = w_wr_en[0];
  assign data_wr2_enable = w_wr_en[1];
  assign data_wr3_enable = w_wr_en[2];
  assign data_wr4_enable = w_wr_en[3];

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_load_store_unit : scoreboard bench with a byte-array memory model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_load_store_unit;
  localparam int AW = 9;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid, req_ready, req_write, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic          resp_valid;
  logic [63:0]   resp_rdata;
  logic [AW-1:0] data_rd1, data_rd2, data_rd3, data_rd4;
  logic [7:0]    data_rd1_out, data_rd2_out, data_rd3_out, data_rd4_out;
  logic [AW-1:0] data_wr1, data_wr2, data_wr3, data_wr4;
  logic [7:0]    data_wr1_data, data_wr2_data, data_wr3_data, data_wr4_data;
  logic          data_wr1_enable, data_wr2_enable, data_wr3_enable, data_wr4_enable;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .data_rd1(data_rd1), .data_rd2(data_rd2), .data_rd3(data_rd3), .data_rd4(data_rd4),
    .data_rd1_out(data_rd1_out), .data_rd2_out(data_rd2_out),
    .data_rd3_out(data_rd3_out), .data_rd4_out(data_rd4_out),
    .data_wr1(data_wr1), .data_wr2(data_wr2), .data_wr3(data_wr3), .data_wr4(data_wr4),
    .data_wr1_data(data_wr1_data), .data_wr2_data(data_wr2_data),
    .data_wr3_data(data_wr3_data), .data_wr4_data(data_wr4_data),
    .data_wr1_enable(data_wr1_enable), .data_wr2_enable(data_wr2_enable),
    .data_wr3_enable(data_wr3_enable), .data_wr4_enable(data_wr4_enable)
  );

  // Byte-wide memory: combinational reads, writes on the rising edge.
  logic [7:0]    mem [0:511];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_data;

  always @(posedge clock) begin
    if (bd_we)           mem[bd_addr]  <= bd_data;
    if (data_wr1_enable) mem[data_wr1] <= data_wr1_data;
    if (data_wr2_enable) mem[data_wr2] <= data_wr2_data;
    if (data_wr3_enable) mem[data_wr3] <= data_wr3_data;
    if (data_wr4_enable) mem[data_wr4] <= data_wr4_data;
  end

  assign data_rd1_out = mem[data_rd1];
  assign data_rd2_out = mem[data_rd2];
  assign data_rd3_out = mem[data_rd3];
  assign data_rd4_out = mem[data_rd4];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    int          due;
  } exp_t;
  exp_t sb [$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest expectation, on its cycle.
  always @(negedge clock) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata %h expected no response", resp_rdata);
      end else begin
        mon_e = sb.pop_front();
        check("resp_rdata", resp_rdata, mon_e.rdata);
        check("resp_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic check_wr(input string tag, input logic [3:0] en,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                          input logic [31:0] d);
    check({tag, "_en"}, 64'({data_wr4_enable, data_wr3_enable, data_wr2_enable, data_wr1_enable}), 64'(en));
    check({tag, "_addr"}, 64'({data_wr4, data_wr3, data_wr2, data_wr1}), 64'({a3, a2, a1, a0}));
    check({tag, "_data"}, 64'({data_wr4_data, data_wr3_data, data_wr2_data, data_wr1_data}), 64'(d));
  endtask

  // Issue one request; leaves time #1 after the accepting edge (BEAT0).
  task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [AW-1:0] a, input logic [63:0] wd, input logic [63:0] exp_rd);
    int n = 0;
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: got req_ready 0 expected 1");
    end
    sb.push_back('{exp_rd, cyc + ((sz == 2'b11) ? 3 : 2)});
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL resp_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = 64'h0;
    repeat (2) @(posedge clock); #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'h0);
    check_wr("rst", 4'b0000, '0, '0, '0, '0, 32'h0);
    check("rst_rd_addr", 64'({data_rd4, data_rd3, data_rd2, data_rd1}), 64'h0);
    for (int i = 0; i < 8; i++) begin
      bd_we = 1'b1; bd_addr = AW'(9'h040 + i); bd_data = 8'hAA;
      @(posedge clock); #1;
    end
    bd_we = 1'b0;
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Word store then loads with extension
    send(1'b1, 2'b10, 1'b0, 9'h010, 64'hDEADBEEF, 64'h0);
    check_wr("wst", 4'b1111, 9'h010, 9'h011, 9'h012, 9'h013, 32'hDEADBEEF);
    check("wst_rd_addr", 64'({data_rd4, data_rd3, data_rd2, data_rd1}), 64'h0);
    check("wst_ready_beat0", 64'(req_ready), 64'd0);
    wait_idle();
    send(1'b0, 2'b10, 1'b0, 9'h010, 64'h0, 64'h00000000DEADBEEF);
    check("wld_rd_addr", 64'({data_rd4, data_rd3, data_rd2, data_rd1}),
          64'({9'h013, 9'h012, 9'h011, 9'h010}));
    check_wr("wld", 4'b0000, '0, '0, '0, '0, 32'h0);
    wait_idle();
    send(1'b0, 2'b10, 1'b1, 9'h010, 64'h0, 64'hFFFFFFFFDEADBEEF); wait_idle();
    send(1'b0, 2'b00, 1'b1, 9'h013, 64'h0, 64'hFFFFFFFFFFFFFFDE); wait_idle();
    send(1'b0, 2'b00, 1'b0, 9'h013, 64'h0, 64'h00000000000000DE); wait_idle();
    send(1'b0, 2'b01, 1'b1, 9'h010, 64'h0, 64'hFFFFFFFFFFFFBEEF); wait_idle();
    send(1'b0, 2'b01, 1'b0, 9'h010, 64'h0, 64'h000000000000BEEF); wait_idle();

    // Double store wrapping the address space
    send(1'b1, 2'b11, 1'b0, 9'h1FE, 64'h0807060504030201, 64'h0);
    check_wr("dst_b0", 4'b1111, 9'h1FE, 9'h1FF, 9'h000, 9'h001, 32'h04030201);
    @(posedge clock); #1;
    check_wr("dst_b1", 4'b1111, 9'h002, 9'h003, 9'h004, 9'h005, 32'h08070605);
    wait_idle();
    send(1'b0, 2'b11, 1'b1, 9'h1FE, 64'h0, 64'h0807060504030201); wait_idle();
    send(1'b0, 2'b01, 1'b0, 9'h1FF, 64'h0, 64'h0000000000000302); wait_idle();
    send(1'b0, 2'b00, 1'b1, 9'h1FF, 64'h0, 64'h0000000000000002); wait_idle();

    // Half store followed back-to-back by a signed half load
    req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0; req_addr = 9'h020;
    req_wdata = 64'h0000000012348765; req_valid = 1'b1;
    check("b2b_ready_idle", 64'(req_ready), 64'd1);
    sb.push_back('{64'h0, cyc + 2});
    @(posedge clock); #1;
    check_wr("hst", 4'b0011, 9'h020, 9'h021, 9'h000, 9'h000, 32'h00008765);
    check("b2b_ready_beat0", 64'(req_ready), 64'd0);
    req_write = 1'b0; req_signed = 1'b1; req_wdata = 64'h0;
    sb.push_back('{64'hFFFFFFFFFFFF8765, cyc + 3});
    @(posedge clock); #1;
    check("b2b_resp_valid", 64'(resp_valid), 64'd1);
    check("b2b_ready_resp", 64'(req_ready), 64'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("b2b_accepted", 64'(req_ready), 64'd0);
    wait_idle();

    // Reset asserted during BEAT1 of a double store
    req_write = 1'b1; req_size = 2'b11; req_signed = 1'b0; req_addr = 9'h040;
    req_wdata = 64'h8877665544332211; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    check_wr("abort_b1", 4'b1111, 9'h044, 9'h045, 9'h046, 9'h047, 32'h88776655);
    reset = 1'b0;
    #1;
    check("abort_en", 64'({data_wr4_enable, data_wr3_enable, data_wr2_enable, data_wr1_enable}), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd0);
    @(posedge clock);
    @(negedge clock) reset = 1'b1;
    #1;
    check("abort_ready_release", 64'(req_ready), 64'd1);
    repeat (3) @(posedge clock); #1;
    check("abort_mem_lo", 64'({mem[9'h043], mem[9'h042], mem[9'h041], mem[9'h040]}), 64'h44332211);
    check("abort_mem_hi", 64'({mem[9'h047], mem[9'h046], mem[9'h045], mem[9'h044]}), 64'hAAAAAAAA);
    send(1'b0, 2'b11, 1'b0, 9'h040, 64'h0, 64'hAAAAAAAA44332211); wait_idle();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit sitting directly upstream of the data memory. It accepts one core-side memory request at a time and splits it into per-byte accesses on the memory's four byte-wide read ports and four write ports. Requests may be 1, 2, 4 or 8 bytes, little-endian, at any alignment. For loads it assembles and sign- or zero-extends the result.

## Interface

Parameters:
- ADDR_WIDTH, 9: byte-address width; matches the data memory port address width.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 double
- req_signed  in  1  load result sign-extended when 1, zero-extended when 0
- req_addr  in  ADDR_WIDTH  byte address of least-significant byte
- req_wdata  in  64  store data; only the low size bytes are used
- resp_valid  out  1  one-cycle pulse: load data valid or store complete
- resp_rdata  out  64  load result; 0 for stores
- data_rd1..data_rd4  out  ADDR_WIDTH  memory read addresses, lanes 0..3
- data_rd1_out..data_rd4_out  in  8  memory read data, combinational from the address
- data_wr1..data_wr4  out  ADDR_WIDTH  memory write addresses, lanes 0..3
- data_wr1_data..data_wr4_data  out  8  memory write data
- data_wr1_enable..data_wr4_enable  out  1  memory write enables

## Operation

- FSM states: IDLE, BEAT0, BEAT1.
- IDLE:
  - req_ready = 1, but 0 while reset is low.
  - On req_valid & req_ready, latch addr, size, write, signed and wdata, then go to BEAT0.
- BEAT0:
  - Lane i (0..3) is active if i < bytes(size). Bytes: 1/2/4/8; double counts all 4 lanes active.
  - Active lane addresses are (addr + i) mod 2^ADDR_WIDTH.
  - Store: active lanes drive wr address, wdata byte i, enable = 1.
  - Load: active lanes drive the rd address. Read data is captured into result byte i at the clock edge.
  - Next state: BEAT1 if size == double, otherwise IDLE with resp_valid set.
- BEAT1 (double only):
  - All four lanes active at (addr + 4 + i) mod 2^ADDR_WIDTH.
  - Bytes 4..7 are written (store) or captured (load).
  - Next state is IDLE with resp_valid set.
- Inactive lanes and all lanes in IDLE drive address 0, data 0, enable 0. Read and write address outputs are driven only for their own access type; the other set is 0.
- Load result:
  - Bytes above the loaded size are filled with 0x00, or with 0xFF when req_signed = 1 and the MSB of the highest loaded byte is 1.
  - Double loads ignore req_signed.
- Store response: resp_rdata = 0 and resp_valid pulses once.
- Active lanes within one beat always target distinct addresses, so no intra-beat write collision is possible.

## Timing

- Request accepted in cycle N.
  - Single-beat request: BEAT0 in N+1, resp_valid in N+2.
  - Double request: BEAT0 in N+1, BEAT1 in N+2, resp_valid in N+3.
- resp_valid and resp_rdata are registered. resp_rdata holds its value until the next response and is not cleared after the pulse.
- The FSM is in IDLE during the resp_valid cycle, so a new request can be accepted in that same cycle.
- Peak throughput is one single-beat request every 2 cycles.
- Store bytes become visible in memory at the rising edge that ends the beat.
- Memory outputs are combinational from state and latched request only, never from req_* inputs directly.
- Reset values:
  - state = IDLE.
  - All latched request fields = 0.
  - resp_valid = 0, resp_rdata = 0.
  - All memory-port outputs = 0.
- Reset mid-operation:
  - Asserting reset low immediately forces all enables to 0 and returns the FSM to IDLE.
  - No resp_valid is produced for the aborted request.
  - Bytes written at earlier edges remain in memory.
- req_valid without ready: the request must be held by the requester. The unit accepts nothing outside IDLE.

## Test plan

- Word store then load:
  - Store addr 0x010, wdata 0xDEADBEEF: lanes 0..3 write 0x010..0x013 with EF, BE, AD, DE, enables 1111; resp_valid at N+2.
  - Unsigned word load from 0x010: resp_rdata = 0x00000000DEADBEEF.
- Byte loads with extension, after the word store:
  - Signed byte load at 0x013: resp_rdata = 0xFFFFFFFFFFFFFFDE.
  - Unsigned byte load at 0x013: resp_rdata = 0x00000000000000DE.
  - Signed half load at 0x010: resp_rdata = 0xFFFFFFFFFFFFBEEF.
- Double store with wrap:
  - Store at 0x1FE, wdata 0x0807060504030201: BEAT0 writes 1FE, 1FF, 000, 001 with 01..04; BEAT1 writes 002..005 with 05..08.
  - Double load from 0x1FE returns the same value; resp_valid at N+3.
- Half store and back-to-back requests:
  - Half store at 0x020: only lanes 0..1 are enabled; lanes 2..3 show address 0, enable 0.
  - With req_valid held high for two requests, the second is accepted in the first's resp_valid cycle, and req_ready = 0 during BEAT0.
- Reset during BEAT1 of a double store to 0x040:
  - Enables drop to 0 immediately and resp_valid never asserts.
  - Bytes 0x040..0x043 are written; 0x044..0x047 are unchanged.
  - req_ready = 1 on the first cycle after reset releases.
